// File: rtl/bomberman_pkg.sv
// Shared constants for the bomberman video path.
// Layer indices follow compositor priority order.
package bomberman_pkg;

  localparam int RGB_W = 12;
  localparam int N_LAYERS_DEF = 6;
  localparam logic [11:0] BG_DEFAULT = 12'h69C;

  localparam int LAYER_PLAYER    = 0;
  localparam int LAYER_BREAKABLE = 1;
  localparam int LAYER_ENEMY     = 2;
  localparam int LAYER_BOMB      = 3;
  localparam int LAYER_EXPLOSION = 4;
  localparam int LAYER_WALL      = 5;

endpackage

// File: rtl/layer_prio_enc.sv
// Lowest-index-wins priority encoder with one-hot grant.
// Shared by the compositor and the collision logic.
module layer_prio_enc #(
  parameter int N = 6
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic         valid
);

  // Two's-complement trick isolates the lowest set bit.
  assign grant = req & (~req + N'(1));
  assign valid = |req;

endmodule

// File: rtl/layer_compositor.sv
// Two-stage priority compositor with colour key, blink,
// frame-latched config and player overlap reporting.
module layer_compositor #(
  parameter int          N_LAYERS   = 6,
  parameter int          RGB_W      = bomberman_pkg::RGB_W,
  parameter int          BLINK_LOG2 = 4,
  parameter logic [RGB_W-1:0] BG_RESET =
    RGB_W'(bomberman_pkg::BG_DEFAULT)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bright,
  input  logic                      v_sync,
  input  logic [N_LAYERS-1:0]       layer_on,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [N_LAYERS-1:0]       cfg_mask,
  input  logic [N_LAYERS-1:0]       cfg_blink,
  input  logic [RGB_W-1:0]          cfg_bg,
  input  logic [RGB_W-1:0]          cfg_key,
  input  logic                      cfg_key_en,
  output logic [RGB_W-1:0]          vga_rgb,
  output logic [N_LAYERS-1:0]       overlap_mask,
  output logic                      frame_tick
);

  import bomberman_pkg::*;

  localparam int N = N_LAYERS;
  localparam int W = RGB_W;

  logic             vs_prev;
  logic             boundary;
  logic [N-1:0]     s1_on;
  logic [N*W-1:0]   s1_rgb;
  logic             s1_bright;

  logic [N-1:0]     sh_mask;
  logic [N-1:0]     sh_blink;
  logic [W-1:0]     sh_bg;
  logic [W-1:0]     sh_key;
  logic             sh_key_en;
  logic [BLINK_LOG2:0] frame_cnt;
  logic [N-1:0]     acc;

  logic             blink_ph;
  logic [N-1:0]     qual;
  logic [N-1:0]     grant;
  logic             win_valid;
  logic [W-1:0]     win_rgb;
  logic [W-1:0]     nxt_rgb;
  logic [N-1:0]     hit;

  assign boundary = ~v_sync & vs_prev;
  assign blink_ph = frame_cnt[BLINK_LOG2];

  always_comb begin
    qual = '0;
    for (int i = 0; i < N; i++) begin
      qual[i] = s1_on[i] & sh_mask[i]
              & ~(blink_ph & sh_blink[i])
              & ~(sh_key_en &
                  (s1_rgb[i*W +: W] == sh_key));
    end
  end

  layer_prio_enc #(.N(N)) u_prio (
    .req   (qual),
    .grant (grant),
    .valid (win_valid)
  );

  // Grant is one-hot, so an AND-OR mux selects the winner.
  always_comb begin
    win_rgb = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) win_rgb = win_rgb | s1_rgb[i*W +: W];
    end
  end

  always_comb begin
    nxt_rgb = '0;
    if (s1_bright) nxt_rgb = win_valid ? win_rgb : sh_bg;
  end

  always_comb begin
    hit = '0;
    if (s1_bright && qual[LAYER_PLAYER])
      hit = {qual[N-1:1], 1'b0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_prev      <= 1'b1;
      s1_on        <= '0;
      s1_rgb       <= '0;
      s1_bright    <= 1'b0;
      sh_mask      <= '1;
      sh_blink     <= '0;
      sh_bg        <= BG_RESET;
      sh_key       <= '0;
      sh_key_en    <= 1'b0;
      frame_cnt    <= '0;
      acc          <= '0;
      vga_rgb      <= '0;
      overlap_mask <= '0;
      frame_tick   <= 1'b0;
    end else begin
      vs_prev    <= v_sync;
      s1_on      <= layer_on;
      s1_rgb     <= layer_rgb;
      s1_bright  <= bright;
      vga_rgb    <= nxt_rgb;
      frame_tick <= boundary;
      if (boundary) begin
        sh_mask      <= cfg_mask;
        sh_blink     <= cfg_blink;
        sh_bg        <= cfg_bg;
        sh_key       <= cfg_key;
        sh_key_en    <= cfg_key_en;
        frame_cnt    <= frame_cnt + 1'b1;
        overlap_mask <= acc;
        acc          <= '0;
      end else begin
        acc <= acc | hit;
      end
    end
  end

endmodule

// File: tb/tb_layer_compositor.sv
// Directed tables plus randomized run against a
// pixel-level reference model of the compositor.
module tb_layer_compositor;
  import bomberman_pkg::*;

  localparam int N  = 6;
  localparam int W  = 12;
  localparam int BL = 1;
  localparam logic [W-1:0] BG = 12'h69C;

  logic           clk = 1'b0;
  logic           reset;
  logic           bright;
  logic           v_sync;
  logic [N-1:0]   layer_on;
  logic [N*W-1:0] layer_rgb;
  logic [N-1:0]   cfg_mask;
  logic [N-1:0]   cfg_blink;
  logic [W-1:0]   cfg_bg;
  logic [W-1:0]   cfg_key;
  logic           cfg_key_en;
  logic [W-1:0]   vga_rgb;
  logic [N-1:0]   overlap_mask;
  logic           frame_tick;

  always #5 clk = ~clk;

  layer_compositor #(
    .N_LAYERS(N), .RGB_W(W), .BLINK_LOG2(BL), .BG_RESET(BG)
  ) dut (
    .clk(clk), .reset(reset), .bright(bright),
    .v_sync(v_sync), .layer_on(layer_on),
    .layer_rgb(layer_rgb), .cfg_mask(cfg_mask),
    .cfg_blink(cfg_blink), .cfg_bg(cfg_bg),
    .cfg_key(cfg_key), .cfg_key_en(cfg_key_en),
    .vga_rgb(vga_rgb), .overlap_mask(overlap_mask),
    .frame_tick(frame_tick)
  );

  int checks = 0;
  int errors = 0;

  logic [N-1:0] m_mask, m_blink, m_acc, m_ovl, p_hit;
  logic [W-1:0] m_bg, m_key, m_vga, p_rgb;
  logic         m_key_en, m_vs, m_tick;
  int           m_frame;

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endfunction

  // Winner = first qualified layer in index order.
  function automatic void eval(
    input  logic [N-1:0]   on,
    input  logic [N*W-1:0] rgb,
    input  logic           br,
    output logic [W-1:0]   o,
    output logic [N-1:0]   h);
    bit q[N];
    int win;
    bit ph;
    ph  = (m_frame >= 2**BL);
    win = -1;
    for (int i = 0; i < N; i++) begin
      q[i] = on[i] && m_mask[i] && !(ph && m_blink[i])
          && !(m_key_en && rgb[i*W +: W] == m_key);
      if (q[i] && win < 0) win = i;
    end
    if (!br) o = '0;
    else if (win < 0) o = m_bg;
    else o = rgb[win*W +: W];
    h = '0;
    if (br && q[0])
      for (int i = 1; i < N; i++) h[i] = q[i];
  endfunction

  function automatic void model_edge();
    bit bnd;
    if (reset) begin
      m_mask = '1; m_blink = '0; m_bg = BG;
      m_key = '0; m_key_en = 1'b0; m_frame = 0;
      m_vs = 1'b1; m_acc = '0; m_ovl = '0;
      m_tick = 1'b0; m_vga = '0;
      p_rgb = '0; p_hit = '0;
    end else begin
      bnd = !v_sync && m_vs;
      m_vs = v_sync;
      m_vga = p_rgb;
      m_tick = bnd;
      if (bnd) begin
        m_ovl = m_acc; m_acc = '0;
        m_mask = cfg_mask; m_blink = cfg_blink;
        m_bg = cfg_bg; m_key = cfg_key;
        m_key_en = cfg_key_en;
        m_frame = (m_frame + 1) % (2**(BL+1));
      end else begin
        m_acc = m_acc | p_hit;
      end
      eval(layer_on, layer_rgb, bright, p_rgb, p_hit);
    end
  endfunction

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("model_vga", vga_rgb, m_vga);
    chk("model_ovl", overlap_mask, m_ovl);
    chk("model_tick", frame_tick, m_tick);
  endtask

  task automatic boundary();
    bright = 1'b0; layer_on = '0;
    v_sync = 1'b0; step();
    chk("tick_pulse", frame_tick, 1);
    step();
    chk("tick_clear", frame_tick, 0);
    v_sync = 1'b1; step();
  endtask

  task automatic pixel(input logic [N-1:0] on);
    layer_on = on; bright = 1'b1;
    step(); step();
  endtask

  typedef struct {
    logic [N-1:0] on;
    logic         br;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[6];
  logic [N*W-1:0] base_rgb;
  logic [W-1:0]   blink_exp[4];
  logic [W-1:0]   pool[4];
  int             vs_low;

  initial begin
    base_rgb = {12'h5A5, 12'h444, 12'h333,
                12'h222, 12'h111, 12'hF00};
    tbl[0] = '{6'b010110, 1'b1, 12'h111};
    tbl[1] = '{6'b000000, 1'b1, BG};
    tbl[2] = '{6'b000001, 1'b0, 12'h000};
    tbl[3] = '{6'b100000, 1'b1, 12'h5A5};
    tbl[4] = '{6'b111111, 1'b1, 12'hF00};
    tbl[5] = '{6'b101000, 1'b1, 12'h333};
    blink_exp = '{12'h444, BG, BG, 12'h444};

    reset = 1'b1; bright = 1'b0; v_sync = 1'b1;
    layer_on = '0; layer_rgb = base_rgb;
    cfg_mask = '1; cfg_blink = '0; cfg_bg = BG;
    cfg_key = '0; cfg_key_en = 1'b0;
    step(); step();
    chk("rst_vga", vga_rgb, 0);
    chk("rst_ovl", overlap_mask, 0);
    chk("rst_tick", frame_tick, 0);
    reset = 1'b0;
    step();

    for (int k = 0; k < 6; k++) begin
      layer_on = tbl[k].on; bright = tbl[k].br;
      step(); step();
      chk($sformatf("tbl%0d", k), vga_rgb, tbl[k].exp);
    end

    // Colour key hides layer 0, layer 3 wins.
    cfg_key = 12'hF0F; cfg_key_en = 1'b1;
    boundary();
    layer_rgb = base_rgb;
    layer_rgb[0 +: W] = 12'hF0F;
    layer_rgb[3*W +: W] = 12'h123;
    pixel(6'b001001);
    chk("key", vga_rgb, 12'h123);
    cfg_key_en = 1'b0; cfg_key = '0;
    boundary();
    layer_rgb = base_rgb;

    // Mask change waits for the frame boundary.
    cfg_mask = 6'b111110;
    pixel(6'b000001);
    chk("latch_before", vga_rgb, 12'hF00);
    boundary();
    pixel(6'b000001);
    chk("latch_after", vga_rgb, BG);

    reset = 1'b1; step();
    chk("rst_mid_vga", vga_rgb, 0);
    reset = 1'b0;
    cfg_mask = '1;
    pixel(6'b000001);
    chk("rst_cfg", vga_rgb, 12'hF00);

    cfg_blink = 6'b010000;
    for (int k = 0; k < 4; k++) begin
      boundary();
      pixel(6'b010000);
      chk($sformatf("blink%0d", k), vga_rgb, blink_exp[k]);
    end
    cfg_blink = '0;
    boundary();
    boundary();

    layer_on = 6'b010001; bright = 1'b1; step();
    layer_on = '0; bright = 1'b0; step(); step();
    boundary();
    chk("ovl_set", overlap_mask, 6'b010000);
    boundary();
    chk("ovl_clear", overlap_mask, 0);

    vs_low = 0;
    for (int c = 0; c < 4000; c++) begin
      pool[0] = 12'h000; pool[1] = 12'hF0F;
      pool[2] = 12'h123; pool[3] = W'($urandom);
      for (int i = 0; i < N; i++)
        layer_rgb[i*W +: W] = pool[$urandom_range(3)];
      layer_on   = N'($urandom);
      bright     = ($urandom_range(3) != 0);
      cfg_mask   = N'($urandom) | 6'b000001;
      cfg_blink  = N'($urandom);
      cfg_bg     = W'($urandom);
      cfg_key    = pool[$urandom_range(3)];
      cfg_key_en = $urandom_range(1) == 1;
      reset      = ($urandom_range(599) == 0);
      if (vs_low > 0) begin
        v_sync = 1'b0; vs_low--;
      end else if ($urandom_range(39) == 0) begin
        v_sync = 1'b0; vs_low = $urandom_range(3);
      end else begin
        v_sync = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
